// File: rtl/axi_stream_strip_header.sv
// ---------------------------------------------------------------------------
// axi_stream_strip_header
//   Removes S leading bytes (S = byte_strip_cnt, one command per packet) from
//   an MSB-first AXI-Stream packet and re-packs the remainder so that every
//   output beat is full except the last, which is left-aligned.
//   Optional feature macro: STRIP_HDR_CAPTURE_EN
//     defined   -> hdr_valid_out / hdr_data_out / hdr_keep_out report the
//                  removed bytes, right-aligned, when the first beat is taken
//     undefined -> removed bytes are discarded, no extra ports or logic
// ---------------------------------------------------------------------------
module axi_stream_strip_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    ready_strip,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out
`ifdef STRIP_HDR_CAPTURE_EN
    ,
    output logic                    hdr_valid_out,
    output logic [DATA_WD-1:0]      hdr_data_out,
    output logic [DATA_BYTE_WD-1:0] hdr_keep_out
`endif
);

    localparam int CNT_WD    = $clog2(DATA_BYTE_WD + 1);
    localparam int BYTE_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    // Keep vector with the top n byte lanes set (left-aligned)
    function automatic logic [DATA_BYTE_WD-1:0] keep_top(input int n);
        logic [DATA_BYTE_WD-1:0] k;
        k = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (i < n) begin
                k[DATA_BYTE_WD-1-i] = 1'b1;
            end else begin
                k[DATA_BYTE_WD-1-i] = 1'b0;
            end
        end
        return k;
    endfunction

    // Expand a byte keep vector into a bit mask over the data bus
    function automatic logic [DATA_WD-1:0] keep_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (k[i]) begin
                m[BYTE_BITS*i +: BYTE_BITS] = 8'hFF;
            end else begin
                m[BYTE_BITS*i +: BYTE_BITS] = 8'h00;
            end
        end
        return m;
    endfunction

    // Number of contiguous set keep bits counted down from the MSB lane
    function automatic int lead_ones(input logic [DATA_BYTE_WD-1:0] k);
        int   n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = DATA_BYTE_WD - 1; i >= 0; i--) begin
            if (run && k[i]) begin
                n = n + 1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    state_t                  state_q, state_d;
    logic [BYTE_CNT_WD-1:0]  s_q, s_d;
    logic [DATA_WD-1:0]      residue_q, residue_d;
    logic [CNT_WD-1:0]       flush_cnt_q, flush_cnt_d;
    logic                    ready_strip_q, ready_strip_d;
    logic                    valid_out_q, valid_out_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
    logic                    last_out_q, last_out_d;

    logic                    load_s;
    logic                    ready_in_s;
    logic                    acc_in_s;
    logic                    acc_strip_s;
    int                      s_int_s;
    int                      lead_s;
    logic [DATA_WD-1:0]      shifted_s;
    logic [DATA_WD-1:0]      top_s;
    logic [DATA_WD-1:0]      full_s;

    // Shifted views of the incoming beat: residue part, head part, joined beat
    always_comb begin
        s_int_s   = int'(s_q);
        lead_s    = lead_ones(keep_in);
        shifted_s = data_in << (BYTE_BITS * s_int_s);
        // With S=0 the shift equals the bus width and yields zero, as intended
        top_s     = data_in >> (BYTE_BITS * (DATA_BYTE_WD - s_int_s));
        full_s    = residue_q | top_s;
    end

    // Handshake decode: the output register can take a beat when empty or draining
    always_comb begin
        load_s = !valid_out_q || ready_out;
        if ((state_q == ST_FIRST) || (state_q == ST_STREAM)) begin
            ready_in_s = load_s;
        end else begin
            ready_in_s = 1'b0;
        end
        acc_in_s    = valid_in && ready_in_s;
        acc_strip_s = valid_strip && ready_strip_q;
    end

    // Next-state and output-register computation for the strip FSM
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        residue_d   = residue_q;
        flush_cnt_d = flush_cnt_q;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;
        if (valid_out_q && ready_out) begin
            valid_out_d = 1'b0;
        end else begin
            valid_out_d = valid_out_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (acc_strip_s) begin
                    s_d     = byte_strip_cnt;
                    state_d = ST_FIRST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FIRST: begin
                if (acc_in_s) begin
                    residue_d = shifted_s;
                    if (!last_in) begin
                        state_d = ST_STREAM;
                    end else begin
                        // Single-beat packet: emit only what survives the strip
                        state_d = ST_IDLE;
                        if (lead_s > s_int_s) begin
                            valid_out_d = 1'b1;
                            keep_out_d  = keep_top(lead_s - s_int_s);
                            data_out_d  = shifted_s & keep_mask(keep_top(lead_s - s_int_s));
                            last_out_d  = 1'b1;
                        end else begin
                            residue_d = '0;
                        end
                    end
                end else begin
                    state_d = ST_FIRST;
                end
            end
            ST_STREAM: begin
                if (acc_in_s) begin
                    residue_d   = shifted_s;
                    valid_out_d = 1'b1;
                    if (!last_in) begin
                        data_out_d = full_s;
                        keep_out_d = '1;
                        last_out_d = 1'b0;
                    end else if (lead_s <= s_int_s) begin
                        // Whole tail fits in this beat
                        keep_out_d = keep_top(DATA_BYTE_WD - s_int_s + lead_s);
                        data_out_d = full_s & keep_mask(keep_top(DATA_BYTE_WD - s_int_s + lead_s));
                        last_out_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        // Tail spills over: one more beat carries L-S residue bytes
                        data_out_d  = full_s;
                        keep_out_d  = '1;
                        last_out_d  = 1'b0;
                        flush_cnt_d = CNT_WD'(lead_s - s_int_s);
                        state_d     = ST_FLUSH;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_FLUSH: begin
                if (load_s) begin
                    valid_out_d = 1'b1;
                    keep_out_d  = keep_top(int'(flush_cnt_q));
                    data_out_d  = residue_q & keep_mask(keep_top(int'(flush_cnt_q)));
                    last_out_d  = 1'b1;
                    residue_d   = '0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_strip_d = (state_d == ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            s_q           <= '0;
            residue_q     <= '0;
            flush_cnt_q   <= '0;
            ready_strip_q <= 1'b0;
            valid_out_q   <= 1'b0;
            data_out_q    <= '0;
            keep_out_q    <= '0;
            last_out_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_q           <= s_d;
            residue_q     <= residue_d;
            flush_cnt_q   <= flush_cnt_d;
            ready_strip_q <= ready_strip_d;
            valid_out_q   <= valid_out_d;
            data_out_q    <= data_out_d;
            keep_out_q    <= keep_out_d;
            last_out_q    <= last_out_d;
        end
    end

    assign ready_in    = ready_in_s;
    assign ready_strip = ready_strip_q;
    assign valid_out   = valid_out_q;
    assign data_out    = data_out_q;
    assign keep_out    = keep_out_q;
    assign last_out    = last_out_q;

`ifdef STRIP_HDR_CAPTURE_EN
    // Keep vector with the low n byte lanes set (right-aligned)
    function automatic logic [DATA_BYTE_WD-1:0] keep_low(input int n);
        logic [DATA_BYTE_WD-1:0] k;
        k = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (i < n) begin
                k[i] = 1'b1;
            end else begin
                k[i] = 1'b0;
            end
        end
        return k;
    endfunction

    logic                    hdr_valid_q, hdr_valid_d;
    logic [DATA_WD-1:0]      hdr_data_q, hdr_data_d;
    logic [DATA_BYTE_WD-1:0] hdr_keep_q, hdr_keep_d;

    // Capture the removed head bytes when the first beat of a packet is taken
    always_comb begin
        hdr_data_d = hdr_data_q;
        hdr_keep_d = hdr_keep_q;
        if ((state_q == ST_FIRST) && acc_in_s && (s_q != '0)) begin
            hdr_valid_d = 1'b1;
            hdr_data_d  = top_s;
            hdr_keep_d  = keep_low(s_int_s);
        end else begin
            hdr_valid_d = 1'b0;
        end
    end

    // Header capture registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_valid_q <= 1'b0;
            hdr_data_q  <= '0;
            hdr_keep_q  <= '0;
        end else begin
            hdr_valid_q <= hdr_valid_d;
            hdr_data_q  <= hdr_data_d;
            hdr_keep_q  <= hdr_keep_d;
        end
    end

    assign hdr_valid_out = hdr_valid_q;
    assign hdr_data_out  = hdr_data_q;
    assign hdr_keep_out  = hdr_keep_q;
`endif

endmodule
